// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-unit bus bundle (branch redirect, imem read port, decode output)
interface fetch_unit_if;
  logic redirect_valid;
  logic [15:0] redirect_pc;
  logic stall;
  logic imem_req;
  logic [15:0] imem_addr;
  logic imem_ready;
  logic [15:0] imem_data;
  logic inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic halted;
  modport master (
    input redirect_valid, redirect_pc, stall, imem_ready, imem_data,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, halted
  );
  modport slave (
    output redirect_valid, redirect_pc, stall, imem_ready, imem_data,
    input imem_req, imem_addr, inst_valid, inst, inst_pc, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one imem read at a time, buffering it for decode, honouring redirects and HLT
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input logic clk,
  input logic rst_n,
  fetch_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, HOLD, FLUSH, HALTED} stateT;
  stateT state, stateNext;
  logic [15:0] fetchPc, fetchPcNext, instBuf, instBufNext, instPc, instPcNext;
  logic [15:0] pendingPc, pendingPcNext, target;
  assign target = {bus.redirect_pc[15:1], 1'b0};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fetchPc <= RESET_PC;
      instBuf <= '0;
      instPc <= '0;
      pendingPc <= '0;
    end else begin
      state <= stateNext;
      fetchPc <= fetchPcNext;
      instBuf <= instBufNext;
      instPc <= instPcNext;
      pendingPc <= pendingPcNext;
    end
  end
  always_comb begin
    stateNext = state;
    fetchPcNext = fetchPc;
    instBufNext = instBuf;
    instPcNext = instPc;
    pendingPcNext = pendingPc;
    case (state)
      IDLE: begin
        stateNext = REQ;
        if (bus.redirect_valid) fetchPcNext = target;
      end
      REQ: begin
        if (bus.redirect_valid) begin
          // an unanswered request must run to completion on its old address
          if (bus.imem_ready) fetchPcNext = target;
          else begin
            pendingPcNext = target;
            stateNext = FLUSH;
          end
        end else if (bus.imem_ready) begin
          instBufNext = bus.imem_data;
          instPcNext = fetchPc;
          fetchPcNext = fetchPc + 16'd2;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          fetchPcNext = target;
          stateNext = REQ;
        end else if (!bus.stall) stateNext = (instBuf[15:12] == HLT_OPCODE) ? HALTED : REQ;
      end
      FLUSH: begin
        if (bus.redirect_valid) pendingPcNext = target;
        if (bus.imem_ready) begin
          fetchPcNext = bus.redirect_valid ? target : pendingPc;
          stateNext = REQ;
        end
      end
      default: ;
    endcase
  end
  assign bus.imem_req = (state == REQ) || (state == FLUSH);
  assign bus.imem_addr = fetchPc;
  assign bus.inst_valid = state == HOLD;
  assign bus.inst = instBuf;
  assign bus.inst_pc = instPc;
  assign bus.halted = state == HALTED;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a transaction-level fetch model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  int lat = 1, reqCnt = 0;
  logic [15:0] memOvr [logic [15:0]];
  logic [15:0] expPc, staleAddr;
  logic expHalted, stale, expReqHi, expValLo, expValHi, firstCycle;

  function automatic logic [15:0] memRead(input logic [15:0] a);
    logic [3:0] op;
    if (memOvr.exists(a)) return memOvr[a];
    op = (a[4:1] == 4'hF) ? 4'h7 : a[4:1];
    return {op, a[12:1] ^ 12'h5A3};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.stall = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_data = '0;
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk("rst_valid", bus.inst_valid, 0);
    chk("rst_inst", bus.inst, 16'h0000);
    chk("rst_pc", bus.inst_pc, 16'h0000);
    chk("rst_halted", bus.halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expPc = 16'h0000;
    staleAddr = 16'h0000;
    expHalted = 0;
    stale = 0;
    expReqHi = 0;
    expValLo = 1;
    expValHi = 0;
    firstCycle = 1;
    reqCnt = 0;
  endtask

  // check outputs against the model, drive one cycle of inputs, advance the model past the edge
  task automatic tick(input logic st, input logic rv, input logic [15:0] rpc);
    logic req, val, rdy;
    logic [15:0] w;
    req = bus.imem_req;
    val = bus.inst_valid;
    if (expHalted) begin
      chk("halt_flag", bus.halted, 1);
      chk("halt_req", req, 0);
      chk("halt_valid", val, 0);
    end else begin
      chk("halted_low", bus.halted, 0);
      if (!firstCycle) chk("live", req | val, 1);
      if (expReqHi) chk("req_hi", req, 1);
      if (expValLo) chk("valid_lo", val, 0);
      if (expValHi) chk("valid_hi", val, 1);
      if (val) begin
        chk("hold_no_req", req, 0);
        chk("inst_pc", bus.inst_pc, expPc);
        chk("inst", bus.inst, memRead(expPc));
      end
      if (req) chk("req_addr", bus.imem_addr, stale ? staleAddr : expPc);
    end
    rdy = 1'b0;
    if (req) rdy = (lat == 0) ? ($urandom % 10 < 6) : (reqCnt == lat - 1);
    reqCnt = (req && !rdy) ? reqCnt + 1 : 0;
    bus.stall = st;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.imem_ready = rdy;
    bus.imem_data = rdy ? memRead(bus.imem_addr) : 16'($urandom);
    expReqHi = 0;
    expValLo = 0;
    expValHi = 0;
    firstCycle = 0;
    if (!expHalted) begin
      if (req && rdy && !stale && !rv) expValHi = 1;
      if (req && rdy && stale && !rv) begin
        expReqHi = 1;
        expValLo = 1;
      end
      if (req && rdy) stale = 0;
      if (rv) begin
        if (req && !rdy) begin
          stale = 1;
          staleAddr = bus.imem_addr;
        end
        expPc = {rpc[15:1], 1'b0};
        expReqHi = 1;
        expValLo = 1;
      end else if (val && !st) begin
        w = memRead(expPc);
        if (w[15:12] == 4'hF) expHalted = 1;
        else begin
          expPc = expPc + 16'd2;
          expReqHi = 1;
          expValLo = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    memOvr[16'h0000] = 16'h1234;
    memOvr[16'h0002] = 16'h2345;
    memOvr[16'h0004] = 16'hF000;
    memOvr[16'h0100] = 16'hF000;
    #2;
    // zero-wait memory, two-cycle cadence
    lat = 1;
    doReset();
    chk("idle_req", bus.imem_req, 0);
    tick(0, 0, 0);
    chk("t1_req", bus.imem_req, 1);
    chk("t1_addr", bus.imem_addr, 16'h0000);
    tick(0, 0, 0);
    chk("t1_valid", bus.inst_valid, 1);
    chk("t1_inst", bus.inst, 16'h1234);
    chk("t1_pc", bus.inst_pc, 16'h0000);
    tick(0, 0, 0);
    chk("t1_req2", bus.imem_req, 1);
    chk("t1_addr2", bus.imem_addr, 16'h0002);
    tick(0, 0, 0);
    chk("t1_inst2", bus.inst, 16'h2345);
    chk("t1_pc2", bus.inst_pc, 16'h0002);
    // 3-cycle latency, then stall in HOLD
    lat = 3;
    doReset();
    tick(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_req", bus.imem_req, 1);
      chk("t2_addr", bus.imem_addr, 16'h0000);
      tick(0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", bus.inst_valid, 1);
      chk("t2_inst", bus.inst, 16'h1234);
      chk("t2_pc", bus.inst_pc, 16'h0000);
      chk("t2_noreq", bus.imem_req, 0);
      tick(1, 0, 0);
    end
    chk("t2_valid_end", bus.inst_valid, 1);
    tick(0, 0, 0);
    chk("t2_req2", bus.imem_req, 1);
    chk("t2_addr2", bus.imem_addr, 16'h0002);
    // redirect during an unanswered request
    lat = 2;
    doReset();
    tick(0, 0, 0);
    tick(0, 1, 16'h0041);
    chk("t3_old_req", bus.imem_req, 1);
    chk("t3_old_addr", bus.imem_addr, 16'h0000);
    chk("t3_valid", bus.inst_valid, 0);
    tick(0, 0, 0);
    chk("t3_valid2", bus.inst_valid, 0);
    chk("t3_req", bus.imem_req, 1);
    chk("t3_addr", bus.imem_addr, 16'h0040);
    // redirect with ready, then redirect cancelling a held HLT
    lat = 1;
    doReset();
    tick(0, 0, 0);
    tick(0, 1, 16'h0100);
    chk("t4_valid", bus.inst_valid, 0);
    chk("t4_addr", bus.imem_addr, 16'h0100);
    tick(0, 0, 0);
    chk("t4_inst", bus.inst, 16'hF000);
    tick(0, 1, 16'h0100);
    chk("t4_nohalt", bus.halted, 0);
    chk("t4_addr2", bus.imem_addr, 16'h0100);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("t4_halt", bus.halted, 1);
    // HLT at 0004, permanent stop until reset
    doReset();
    for (int i = 0; i < 6; i++) tick(0, 0, 0);
    chk("t5_inst", bus.inst, 16'hF000);
    chk("t5_pc", bus.inst_pc, 16'h0004);
    tick(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      chk("t5_halted", bus.halted, 1);
      chk("t5_noreq", bus.imem_req, 0);
      tick(0, i == 5, 16'h0200);
    end
    doReset();
    chk("t5_unhalt", bus.halted, 0);
    tick(0, 0, 0);
    chk("t5_req", bus.imem_req, 1);
    chk("t5_addr", bus.imem_addr, 16'h0000);
    // PC wrap
    doReset();
    tick(0, 1, 16'hFFFF);
    chk("t6_addr", bus.imem_addr, 16'hFFFE);
    tick(0, 0, 0);
    chk("t6_pc", bus.inst_pc, 16'hFFFE);
    tick(0, 0, 0);
    chk("t6_wrap", bus.imem_addr, 16'h0000);
    // asynchronous reset mid-request
    doReset();
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", bus.imem_req, 0);
    chk("ar_addr", bus.imem_addr, 16'h0000);
    chk("ar_valid", bus.inst_valid, 0);
    chk("ar_inst", bus.inst, 16'h0000);
    chk("ar_pc", bus.inst_pc, 16'h0000);
    // randomized traffic against the model
    lat = 0;
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if (expHalted && ($urandom % 6 == 0)) doReset();
      else tick($urandom % 10 < 3, $urandom % 100 < 12, 16'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that owns the architectural PC and turns the next-PC value produced by the branch unit into instruction-memory reads. Issues one 16-bit read at a time over a req/ready handshake, buffers the returned instruction for decode, honours decode stalls, accepts branch redirects at any time, and stops fetching after a HLT instruction is consumed. Sits between the branch unit (redirect source) and decode (instruction sink).

## Interface
Parameters:
- RESET_PC, 16'h0000, first fetch address after reset
- HLT_OPCODE, 4'hF, value of inst[15:12] that marks HLT

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- redirect_valid  input  1  branch unit requests PC change this cycle
- redirect_pc  input  16  target PC; bit 0 ignored (treated as 0)
- stall  input  1  decode cannot accept inst this cycle
- imem_req  output  1  read request to instruction memory
- imem_addr  output  16  read address; stable while imem_req high
- imem_ready  input  1  memory returns data this cycle (valid only while imem_req high)
- imem_data  input  16  instruction word, sampled when imem_req & imem_ready
- inst_valid  output  1  inst/inst_pc hold a fetched instruction
- inst  output  16  buffered instruction
- inst_pc  output  16  address of inst
- halted  output  1  HLT consumed; fetch permanently stopped until reset

## Operation
- Registers: fetch_pc (16b), inst buffer (16b), inst_pc (16b), state, pending_redirect flag + pending_pc (16b).
- States: IDLE, REQ, HOLD, FLUSH, HALTED.
- IDLE: entered on reset; unconditional -> REQ next cycle.
- REQ: imem_req=1, imem_addr=fetch_pc. On imem_ready: capture imem_data to inst, fetch_pc to inst_pc, fetch_pc <= fetch_pc+2, -> HOLD.
- HOLD: inst_valid=1, imem_req=0. Consume = inst_valid & ~stall at a clock edge. On consume: if inst[15:12]==HLT_OPCODE -> HALTED, else -> REQ.
- HALTED: imem_req=0, inst_valid=0, halted=1; redirects ignored; exit only via rst_n.
- Redirect (redirect_valid=1), highest priority over consume/capture:
  - IDLE/HOLD: fetch_pc <= {redirect_pc[15:1],1'b0}, inst_valid drops next cycle, -> REQ. A HLT in HOLD is cancelled (no halt).
  - REQ, imem_ready same cycle: returned data discarded, fetch_pc <= target, -> REQ (new address next cycle).
  - REQ, no imem_ready: request must complete (addr held); store target in pending_pc, -> FLUSH.
  - FLUSH: imem_req=1 with old address; on imem_ready discard data, fetch_pc <= pending_pc, -> REQ. A further redirect in FLUSH overwrites pending_pc.
- PC arithmetic: 16-bit, modulo 2^16 (add_16bit, Cin=0, Cout unused); 16'hFFFE+2 = 16'h0000.
- Stall never affects an outstanding memory request; only HOLD waits on it.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=16'h0000, inst_pc=16'h0000, halted=0; fetch_pc=RESET_PC, state=IDLE.
- First imem_req rises in the 2nd cycle after rst_n deasserts (IDLE cycle, then REQ).
- Zero-wait memory (ready in first req cycle): inst_valid the next cycle; with no stall, one instruction every 2 cycles.
- imem_req/imem_addr are functions of state and registers only (no combinational path from inputs).
- inst, inst_pc stable while inst_valid & stall.
- halted rises the cycle after HLT is consumed.
- rst_n assertion mid-request: all outputs return to reset values immediately (asynchronous); in-flight memory data ignored.

## Test plan
- Reset then zero-wait memory returning 16'h1234 @0000, 16'h2345 @0002, no stall -> imem_req in cycle 2, inst_valid with inst=1234/inst_pc=0000, then 2345/0002, 2-cycle cadence.
- Memory with 3-cycle latency, stall high 4 cycles in HOLD -> imem_addr held 3 cycles, inst/inst_pc unchanged through stall, next req at 0002 only after stall drops.
- Redirect to 16'h0041 during REQ without ready (latency 2) -> old request completes, data discarded, inst_valid stays 0, next req addr 16'h0040.
- Redirect to 16'h0100 in same cycle as imem_ready -> data dropped, next cycle req at 0100; redirect while HOLD holds HLT (F000) -> no halt, fetch 0100.
- HLT 16'hF000 @0004 consumed -> halted=1 next cycle, imem_req stays 0 for 20 cycles, later redirect ignored; rst_n pulse -> halted=0, fetch from 0000.
- fetch_pc redirected to 16'hFFFE -> fetch FFFE then 0000 (wrap).
